// File: rtl/code_entry_shift_reg.sv
// Code-entry shift register.
// Collects DIGITS digits of DIGIT_W bits, one per auth_button press, into a shift register.
// Supports backspace, an inactivity timeout and a live digit count.
// The completed code is presented with valid_bit and held until log_out.
module code_entry_shift_reg #(
    parameter int DIGIT_W = 4,
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 1000,
    localparam int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [DIGIT_W-1:0]          toggle_entry,
    input  logic                        auth_button,
    input  logic                        back_button,
    input  logic                        log_out,
    output logic [DIGITS*DIGIT_W-1:0]   entered,
    output logic                        valid_bit,
    output logic [CNT_W-1:0]            count,
    output logic                        busy,
    output logic                        timeout_flag
);

    localparam int CODE_W = DIGITS * DIGIT_W;
    // Idle counter only has to reach TIMEOUT-1; keep at least one bit so a disabled timeout still elaborates.
    localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              state_reg;
    logic [CODE_W-1:0]   r_reg;
    logic [CODE_W-1:0]   entered_reg;
    logic                valid_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                busy_reg;
    logic                timeout_reg;
    logic [TMR_W-1:0]    idle_reg;
    logic                auth_q_reg;
    logic                back_q_reg;

    logic                auth_edge;
    logic                back_edge;
    logic [CODE_W-1:0]   r_push;
    logic [CODE_W-1:0]   r_pop;

    // A held button gives one press: only the low-to-high transition counts.
    assign auth_edge = auth_button & ~auth_q_reg;
    assign back_edge = back_button & ~back_q_reg;

    // New digit enters the LS field; the oldest digit ends up in the MS field.
    generate
        if (DIGITS == 1) begin : g_push_single
            assign r_push = toggle_entry;
        end else begin : g_push_multi
            assign r_push = {r_reg[CODE_W-DIGIT_W-1:0], toggle_entry};
        end
    endgenerate

    // Backspace drops the most recent digit and zero-fills the MS field.
    assign r_pop = r_reg >> DIGIT_W;

    // Session state machine with all outputs registered alongside the state.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            r_reg       <= '0;
            entered_reg <= '0;
            valid_reg   <= 1'b0;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            idle_reg    <= '0;
            auth_q_reg  <= 1'b0;
            back_q_reg  <= 1'b0;
        end else begin
            auth_q_reg <= auth_button;
            back_q_reg <= back_button;
            case (state_reg)
                IDLE: begin
                    r_reg       <= '0;
                    count_reg   <= '0;
                    entered_reg <= '0;
                    valid_reg   <= 1'b0;
                    if (enable) begin
                        state_reg   <= COLLECT;
                        busy_reg    <= 1'b1;
                        timeout_reg <= 1'b0;
                        idle_reg    <= '0;
                    end
                end
                COLLECT: begin
                    if (log_out) begin
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        r_reg       <= '0;
                        count_reg   <= '0;
                        entered_reg <= '0;
                        valid_reg   <= 1'b0;
                    end else if (back_edge) begin
                        // Backspace wins over a coincident auth press, which is dropped.
                        if (count_reg != '0) begin
                            r_reg     <= r_pop;
                            count_reg <= count_reg - 1'b1;
                        end
                        idle_reg <= '0;
                    end else if (auth_edge) begin
                        r_reg     <= r_push;
                        count_reg <= count_reg + 1'b1;
                        idle_reg  <= '0;
                        if (count_reg == CNT_ALMOST) begin
                            entered_reg <= r_push;
                            valid_reg   <= 1'b1;
                            state_reg   <= DONE;
                        end
                    end else if (TIMEOUT > 0) begin
                        if (idle_reg == TMR_LAST) begin
                            state_reg   <= IDLE;
                            busy_reg    <= 1'b0;
                            timeout_reg <= 1'b1;
                            r_reg       <= '0;
                            count_reg   <= '0;
                        end else if (idle_reg != '1) begin
                            idle_reg <= idle_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Code is frozen here; only log_out releases it.
                    if (log_out) begin
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        r_reg       <= '0;
                        count_reg   <= '0;
                        entered_reg <= '0;
                        valid_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign entered      = entered_reg;
    assign valid_bit    = valid_reg;
    assign count        = count_reg;
    assign busy         = busy_reg;
    assign timeout_flag = timeout_reg;

endmodule

// File: tb/tb_code_entry_shift_reg.sv
// Scoreboard bench for code_entry_shift_reg (DIGITS=4, DIGIT_W=4).
// Instance a uses TIMEOUT=16, instance b shares all inputs but has the timeout disabled.
module tb_code_entry_shift_reg;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  toggle_entry = '0;
    logic        auth_button = 1'b0;
    logic        back_button = 1'b0;
    logic        log_out = 1'b0;

    logic [15:0] entered_a, entered_b;
    logic        valid_a, valid_b;
    logic [2:0]  count_a, count_b;
    logic        busy_a, busy_b;
    logic        tflag_a, tflag_b;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [15:0] ent;
        logic        vld;
        logic [2:0]  cnt;
        logic        bsy;
        logic        tfl;
    } exp_t;

    exp_t sb[$];

    code_entry_shift_reg #(.DIGIT_W(4), .DIGITS(4), .TIMEOUT(16)) dut_a (
        .clock(clock), .rst(rst), .enable(enable), .toggle_entry(toggle_entry),
        .auth_button(auth_button), .back_button(back_button), .log_out(log_out),
        .entered(entered_a), .valid_bit(valid_a), .count(count_a),
        .busy(busy_a), .timeout_flag(tflag_a)
    );

    code_entry_shift_reg #(.DIGIT_W(4), .DIGITS(4), .TIMEOUT(0)) dut_b (
        .clock(clock), .rst(rst), .enable(enable), .toggle_entry(toggle_entry),
        .auth_button(auth_button), .back_button(back_button), .log_out(log_out),
        .entered(entered_b), .valid_bit(valid_b), .count(count_b),
        .busy(busy_b), .timeout_flag(tflag_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] ent, input logic vld,
                           input logic [2:0] cnt, input logic bsy, input logic tfl);
        exp_t e;
        e.tag = tag; e.ent = ent; e.vld = vld; e.cnt = cnt; e.bsy = bsy; e.tfl = tfl;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            $display("[%0t] %s: entered=%h valid=%b count=%0d busy=%b tflag=%b",
                     $time, e.tag, entered_a, valid_a, count_a, busy_a, tflag_a);
            chk({e.tag, ".entered"}, 32'(entered_a), 32'(e.ent));
            chk({e.tag, ".valid"},   32'(valid_a),   32'(e.vld));
            chk({e.tag, ".count"},   32'(count_a),   32'(e.cnt));
            chk({e.tag, ".busy"},    32'(busy_a),    32'(e.bsy));
            chk({e.tag, ".tflag"},   32'(tflag_a),   32'(e.tfl));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        toggle_entry = d;
        auth_button = 1'b1;
        tick();
        auth_button = 1'b0;
        tick();
    endtask

    task automatic back();
        back_button = 1'b1;
        tick();
        back_button = 1'b0;
        tick();
    endtask

    task automatic start();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic logout();
        log_out = 1'b1;
        tick();
        log_out = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick(); tick();
        sb_push("reset", 16'h0000, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        drain();

        // Basic entry 1,2,3,4
        start();
        sb_push("start", 16'h0000, 0, 0, 1, 0);
        drain();
        press(4'h1); press(4'h2); press(4'h3);
        sb_push("three_digits", 16'h0000, 0, 3, 1, 0);
        drain();
        sb_push("code_1234", 16'h1234, 1, 4, 1, 0);
        toggle_entry = 4'h4; auth_button = 1'b1;
        tick();
        drain();
        chk("b.entered_1234", 32'(entered_b), 32'h1234);
        auth_button = 1'b0;
        tick();
        sb_push("logout_done", 16'h0000, 0, 0, 0, 0);
        logout();
        drain();

        // Async reset mid-session after two digits
        start();
        press(4'h1); press(4'h2);
        sb_push("two_digits", 16'h0000, 0, 2, 1, 0);
        drain();
        #2;
        rst = 1'b1;
        #1;
        sb_push("async_reset", 16'h0000, 0, 0, 0, 0);
        drain();
        tick();
        rst = 1'b0;
        tick();
        start();
        sb_push("restart", 16'h0000, 0, 0, 1, 0);
        drain();

        // Backspace: 5,6,back,7,8,9 -> 5789
        press(4'h5); press(4'h6);
        back();
        sb_push("after_back", 16'h0000, 0, 1, 1, 0);
        drain();
        press(4'h7); press(4'h8); press(4'h9);
        sb_push("code_5789", 16'h5789, 1, 4, 1, 0);
        drain();
        logout();
        tick();

        // Held auth button counts once
        start();
        toggle_entry = 4'h3; auth_button = 1'b1;
        repeat (10) tick();
        auth_button = 1'b0;
        tick();
        sb_push("held_once", 16'h0000, 0, 1, 1, 0);
        drain();
        back();
        back();
        sb_push("back_at_zero", 16'h0000, 0, 0, 1, 0);
        drain();

        // Simultaneous auth and back at count=2
        press(4'h2); press(4'h3);
        sb_push("sim_edges", 16'h0000, 0, 1, 1, 0);
        toggle_entry = 4'h9; auth_button = 1'b1; back_button = 1'b1;
        tick();
        drain();
        auth_button = 1'b0; back_button = 1'b0;
        tick();
        press(4'h4); press(4'h5); press(4'h6);
        sb_push("code_2456", 16'h2456, 1, 4, 1, 0);
        drain();

        // DONE lockout
        press(4'h7);
        back();
        start();
        tick();
        sb_push("done_lockout", 16'h2456, 1, 4, 1, 0);
        drain();
        sb_push("done_logout", 16'h0000, 0, 0, 0, 0);
        logout();
        drain();

        // log_out at count=3 in COLLECT
        start();
        press(4'h1); press(4'h2); press(4'h3);
        sb_push("collect_cnt3", 16'h0000, 0, 3, 1, 0);
        drain();
        sb_push("collect_logout", 16'h0000, 0, 0, 0, 0);
        logout();
        drain();

        // Timeout: one press then 16 idle cycles
        start();
        press(4'h1);
        repeat (14) tick();
        sb_push("idle_15", 16'h0000, 0, 1, 1, 0);
        drain();
        tick();
        sb_push("timeout", 16'h0000, 0, 0, 0, 1);
        drain();
        chk("b.busy_no_timeout", 32'(busy_b), 32'd1);
        chk("b.count_no_timeout", 32'(count_b), 32'd1);
        repeat (100) tick();
        chk("b.busy_100_idle", 32'(busy_b), 32'd1);
        chk("b.tflag_100_idle", 32'(tflag_b), 32'd0);
        sb_push("tflag_sticky", 16'h0000, 0, 0, 0, 1);
        drain();
        start();
        sb_push("enable_clears_tflag", 16'h0000, 0, 0, 1, 0);
        drain();
        logout();
        chk("b.logout_idle", 32'(busy_b), 32'd0);
        sb_push("final_idle", 16'h0000, 0, 0, 0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
